cpu_sequencer: RTL

- Multi-cycle control sequencer for the 8-bit accumulator CPU.
- Steps every instruction through 8 fixed phases and drives the control strobes for memory, instruction register, program counter, accumulator and ALU.
- Adds run control on top of the phase machine: start/stop after reset, and halt/resume on HLT.
- Replaces the bare per-opcode controller in the datapath top level.

---
 rtl/cpu_pkg.sv | 79 +++++++
 rtl/cpu_seq_decode.sv | 75 +++++++
 rtl/cpu_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit accumulator CPU control path:
//   - datapath widths (opcode, ALU select, phase counter)
//   - opcode values and ALU operation encodings
//   - names of the eight instruction phases
//   - sequencer top-state encoding
//   - the packed strobe bundle produced by the phase decoder
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int CPU_OPW  = 3;
   localparam int CPU_ALUW = 2;
   localparam int CPU_PHW  = 3;

   localparam logic [CPU_OPW-1:0] OP_HLT = 3'd0;
   localparam logic [CPU_OPW-1:0] OP_SKZ = 3'd1;
   localparam logic [CPU_OPW-1:0] OP_ADD = 3'd2;
   localparam logic [CPU_OPW-1:0] OP_AND = 3'd3;
   localparam logic [CPU_OPW-1:0] OP_XOR = 3'd4;
   localparam logic [CPU_OPW-1:0] OP_LDA = 3'd5;
   localparam logic [CPU_OPW-1:0] OP_STO = 3'd6;
   localparam logic [CPU_OPW-1:0] OP_JMP = 3'd7;

   localparam logic [CPU_ALUW-1:0] ALU_ADD  = 2'b00;
   localparam logic [CPU_ALUW-1:0] ALU_AND  = 2'b01;
   localparam logic [CPU_ALUW-1:0] ALU_XOR  = 2'b10;
   localparam logic [CPU_ALUW-1:0] ALU_PASS = 2'b11;

   localparam logic [CPU_PHW-1:0] PH_INST_ADDR  = 3'd0;
   localparam logic [CPU_PHW-1:0] PH_INST_FETCH = 3'd1;
   localparam logic [CPU_PHW-1:0] PH_INST_LOAD  = 3'd2;
   localparam logic [CPU_PHW-1:0] PH_IDLE       = 3'd3;
   localparam logic [CPU_PHW-1:0] PH_OP_ADDR    = 3'd4;
   localparam logic [CPU_PHW-1:0] PH_OP_FETCH   = 3'd5;
   localparam logic [CPU_PHW-1:0] PH_ALU_OP     = 3'd6;
   localparam logic [CPU_PHW-1:0] PH_STORE      = 3'd7;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUN     = 2'd1,
      HALTED  = 2'd2,
      PAUSED  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic                addr_sel;
      logic                mem_rd;
      logic                mem_wr;
      logic                data_drive;
      logic                ir_load;
      logic                pc_inc;
      logic                pc_load;
      logic                ac_load;
      logic                alu_to_acc;
      logic [CPU_ALUW-1:0] alu_op;
      logic                instr_done;
   } strobes_t;

   // Instructions whose result is loaded into the accumulator from memory
   // (directly or through the ALU).
   function automatic logic is_alu_class(input logic [CPU_OPW-1:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

   // ALU select for an opcode; anything that is not a real ALU operation
   // gets the pass-through encoding.
   function automatic logic [CPU_ALUW-1:0] alu_sel(input logic [CPU_OPW-1:0] op);
      logic [CPU_ALUW-1:0] sel;
      case (op)
         OP_ADD:  sel = ALU_ADD;
         OP_AND:  sel = ALU_AND;
         OP_XOR:  sel = ALU_XOR;
         default: sel = ALU_PASS;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// ---------------------------------------------------------------------------
// cpu_seq_decode
// Purely combinational phase decoder: maps (phase, opcode, zero) to the
// control strobe bundle for one running instruction phase. Run-control
// gating (stopped / halted / reset) is applied by the parent.
// Ports:
//   phase   in  current phase 0..7
//   opcode  in  current IR opcode
//   zero    in  accumulator-is-zero flag
//   strobes out decoded strobe bundle (strobes_t)
// ---------------------------------------------------------------------------
module cpu_seq_decode
   import cpu_pkg::*;
(
   input  logic [CPU_PHW-1:0] phase,
   input  logic [CPU_OPW-1:0] opcode,
   input  logic               zero,
   output strobes_t           strobes
);

   logic alu_cls;

   // Phases 0-3 fetch the instruction from the PC address, phase 4 bumps
   // the PC, phases 5-7 execute using the IR operand address. Memory read
   // and accumulator drive are never asserted together, so STO only drives
   // the bus in phases where no read is in progress.
   always_comb begin
      strobes = '0;
      alu_cls = is_alu_class(opcode);
      case (phase)
         PH_INST_ADDR: begin
            strobes.addr_sel = 1'b1;
         end
         PH_INST_FETCH: begin
            strobes.addr_sel = 1'b1;
            strobes.mem_rd   = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            strobes.addr_sel = 1'b1;
            strobes.mem_rd   = 1'b1;
            strobes.ir_load  = 1'b1;
         end
         PH_OP_ADDR: begin
            strobes.pc_inc = 1'b1;
         end
         PH_OP_FETCH: begin
            strobes.mem_rd = alu_cls;
         end
         PH_ALU_OP: begin
            strobes.mem_rd     = alu_cls;
            strobes.pc_inc     = (opcode == OP_SKZ) && zero;
            strobes.pc_load    = (opcode == OP_JMP);
            strobes.data_drive = (opcode == OP_STO);
         end
         PH_STORE: begin
            strobes.mem_rd     = alu_cls;
            strobes.ac_load    = alu_cls;
            strobes.pc_load    = (opcode == OP_JMP);
            strobes.data_drive = (opcode == OP_STO);
            strobes.mem_wr     = (opcode == OP_STO);
            strobes.instr_done = 1'b1;
         end
         default: begin
         end
      endcase

      // ALU controls are only meaningful while the operand is on its way
      // into the accumulator, so they stay quiet during fetch.
      if (phase >= PH_OP_FETCH) begin
         strobes.alu_op     = alu_sel(opcode);
         strobes.alu_to_acc = alu_cls && (opcode != OP_LDA);
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control sequencer for the 8-bit accumulator CPU. Steps each
// instruction through 8 phases and adds run control (STOPPED / RUN / HALTED,
// plus PAUSED in single-step builds).
// Optional feature macro: CPU_SEQ_SINGLE_STEP_EN adds the step_mode input;
// with step_mode = 1 the sequencer pauses after each completed instruction.
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-low reset
//   go         in  start / resume pulse (STOPPED, HALTED, PAUSED only)
//   step_mode  in  pause after each instruction (single-step builds only)
//   opcode     in  current IR opcode
//   zero       in  accumulator equals zero
//   phase      out current phase, 0 when not running
//   running    out sequencer in RUN
//   halted     out HLT executed
//   instr_done, addr_sel, mem_rd, mem_wr, data_drive, ir_load, pc_inc,
//   pc_load, ac_load, alu_to_acc, alu_op  out  datapath control strobes
// ---------------------------------------------------------------------------
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int OPW  = CPU_OPW,
   parameter int ALUW = CPU_ALUW,
   parameter int PHW  = CPU_PHW
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            go,
`ifdef CPU_SEQ_SINGLE_STEP_EN
   input  logic            step_mode,
`endif
   input  logic [OPW-1:0]  opcode,
   input  logic            zero,
   output logic [PHW-1:0]  phase,
   output logic            running,
   output logic            halted,
   output logic            instr_done,
   output logic            addr_sel,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            data_drive,
   output logic            ir_load,
   output logic            pc_inc,
   output logic            pc_load,
   output logic            ac_load,
   output logic            alu_to_acc,
   output logic [ALUW-1:0] alu_op
);

   seq_state_t     state;
   seq_state_t     state_next;
   logic [PHW-1:0] phase_q;
   logic [PHW-1:0] phase_next;
   logic           run_active;
   strobes_t       dec;
   strobes_t       gated;

   // State register and phase counter; reset lands in STOPPED at phase 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= STOPPED;
         phase_q <= '0;
      end else begin
         state   <= state_next;
         phase_q <= phase_next;
      end
   end

   // Run control. go is only looked at outside RUN, so a pulse arriving in
   // the cycle that executes HLT is lost and a fresh pulse is needed later.
   // The phase counter is parked at 0 whenever the machine is not running.
   always_comb begin
      state_next = state;
      phase_next = phase_q;
      case (state)
         STOPPED, HALTED: begin
            if (go) begin
               state_next = RUN;
               phase_next = '0;
            end
         end
         RUN: begin
            if ((phase_q == PH_OP_ADDR) && (opcode == OP_HLT)) begin
               state_next = HALTED;
               phase_next = '0;
            end else if (phase_q == PH_STORE) begin
               phase_next = '0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
               if (step_mode) begin
                  state_next = PAUSED;
               end
`endif
            end else begin
               phase_next = phase_q + 1'b1;
            end
         end
`ifdef CPU_SEQ_SINGLE_STEP_EN
         PAUSED: begin
            if (go) begin
               state_next = RUN;
               phase_next = '0;
            end
         end
`endif
         default: begin
            state_next = STOPPED;
            phase_next = '0;
         end
      endcase
   end

   cpu_seq_decode u_decode (
      .phase   (phase_q),
      .opcode  (opcode),
      .zero    (zero),
      .strobes (dec)
   );

   // Strobes are gated directly by rst as well as by the state so that no
   // write or load can pulse while reset is held, independent of how the
   // asynchronous clear of the state register propagates.
   always_comb begin
      run_active = rst && (state == RUN);
      gated      = run_active ? dec : '0;
   end

   assign phase      = run_active ? phase_q : '0;
   assign running    = run_active;
   assign halted     = rst && (state == HALTED);
   assign instr_done = gated.instr_done;
   assign addr_sel   = gated.addr_sel;
   assign mem_rd     = gated.mem_rd;
   assign mem_wr     = gated.mem_wr;
   assign data_drive = gated.data_drive;
   assign ir_load    = gated.ir_load;
   assign pc_inc     = gated.pc_inc;
   assign pc_load    = gated.pc_load;
   assign ac_load    = gated.ac_load;
   assign alu_to_acc = gated.alu_to_acc;
   assign alu_op     = gated.alu_op;

endmodule
